// File: rtl/sa_skew_feeder.sv
// Skews unskewed A/B row vectors into the diagonal wavefront a systolic array consumes,
// zero-fills idle lanes, drains the chains after the last vector, then pulses DONE.
module sa_skew_feeder #(
  parameter int WIDTH = 32,
  parameter int N     = 64,
  parameter int DRAIN = 2*N-2
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               IN_VALID,
  output logic               IN_READY,
  input  logic               IN_LAST,
  input  logic [WIDTH*N-1:0] A_IN,
  input  logic [WIDTH*N-1:0] B_IN,
  output logic [WIDTH*N-1:0] AA,
  output logic [WIDTH*N-1:0] BB,
  output logic               BUSY,
  output logic               DONE,
  output logic [15:0]        VEC_CNT
);

  // The last lane needs N-1 extra cycles to leave its chain before DONE.
  generate
    if (DRAIN < N-1 || DRAIN < 1) begin : g_bad_drain
      $error("sa_skew_feeder: DRAIN must be >= N-1 and >= 1");
    end
  endgenerate

  localparam int DCW = $clog2(DRAIN + 2);
  localparam logic [DCW-1:0] DRAIN_C = DCW'(DRAIN);
  localparam logic [DCW-1:0] ONE_C   = DCW'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_STREAM,
    S_FLUSH,
    S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [DCW-1:0]  drain_q, drain_d;
  logic [15:0]     cnt_q, cnt_d;
  logic            accept;

  assign IN_READY = (state_q == S_IDLE) || (state_q == S_STREAM);
  assign BUSY     = (state_q == S_STREAM) || (state_q == S_FLUSH);
  assign DONE     = (state_q == S_DONE);
  assign VEC_CNT  = cnt_q;
  assign accept   = IN_VALID & IN_READY;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      drain_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    drain_d = drain_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          cnt_d = 16'd1;
          if (IN_LAST) begin
            state_d = S_FLUSH;
            drain_d = ONE_C;
          end else begin
            state_d = S_STREAM;
          end
        end
      end
      S_STREAM: begin
        if (accept) begin
          if (cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
          if (IN_LAST) begin
            state_d = S_FLUSH;
            drain_d = ONE_C;
          end
        end
      end
      S_FLUSH: begin
        if (drain_q == DRAIN_C) state_d = S_DONE;
        else                    drain_d = drain_q + ONE_C;
      end
      S_DONE: begin
        state_d = S_IDLE;
        drain_d = '0;
      end
      default: begin
        state_d = S_IDLE;
        drain_d = '0;
      end
    endcase
  end

  // Lane g has g+1 stages; the last stage drives the output lane directly.
  for (genvar g = 0; g < N; g++) begin : g_lane
    logic [WIDTH-1:0] a_sr [0:g];
    logic [WIDTH-1:0] b_sr [0:g];

    always_ff @(posedge CLK) begin
      if (RST) begin
        for (int k = 0; k <= g; k++) begin
          a_sr[k] <= '0;
          b_sr[k] <= '0;
        end
      end else begin
        a_sr[0] <= accept ? A_IN[g*WIDTH +: WIDTH] : '0;
        b_sr[0] <= accept ? B_IN[g*WIDTH +: WIDTH] : '0;
        for (int k = 1; k <= g; k++) begin
          a_sr[k] <= a_sr[k-1];
          b_sr[k] <= b_sr[k-1];
        end
      end
    end

    assign AA[g*WIDTH +: WIDTH] = a_sr[g];
    assign BB[g*WIDTH +: WIDTH] = b_sr[g];
  end

endmodule

// File: tb/tb_sa_skew_feeder.sv
// Directed bench for sa_skew_feeder at N=4, WIDTH=32, DRAIN=6.
module tb_sa_skew_feeder;
  localparam int WIDTH = 32;
  localparam int N     = 4;
  localparam int DRAIN = 6;
  localparam int VW    = WIDTH*N;

  logic          CLK = 1'b0;
  logic          RST;
  logic          IN_VALID;
  logic          IN_READY;
  logic          IN_LAST;
  logic [VW-1:0] A_IN;
  logic [VW-1:0] B_IN;
  logic [VW-1:0] AA;
  logic [VW-1:0] BB;
  logic          BUSY;
  logic          DONE;
  logic [15:0]   VEC_CNT;

  int checks = 0;
  int errors = 0;
  int jv [8];

  sa_skew_feeder #(.WIDTH(WIDTH), .N(N), .DRAIN(DRAIN)) dut (
    .CLK(CLK), .RST(RST), .IN_VALID(IN_VALID), .IN_READY(IN_READY), .IN_LAST(IN_LAST),
    .A_IN(A_IN), .B_IN(B_IN), .AA(AA), .BB(BB), .BUSY(BUSY), .DONE(DONE), .VEC_CNT(VEC_CNT)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [31:0] lanev(input int v, input int off, input int i, input int badd);
    return (v == 0) ? 32'd0 : 32'(v + off*i + badd);
  endfunction

  function automatic logic [VW-1:0] mkvec(input int v, input int off, input int badd);
    logic [VW-1:0] r;
    r = '0;
    for (int i = 0; i < N; i++) r[i*WIDTH +: WIDTH] = lanev(v, off, i, badd);
    return r;
  endfunction

  // jv[0..len-1] holds the job; 0 is a bubble. A lane i = v + off*i, B lane = A lane + 256.
  task automatic run_job(input string name, input int len, input int off, input bit flush_valid);
    logic [VW-1:0] ea, eb;
    int d, ecnt;
    ecnt = 0;
    for (int j = 1; j <= len + DRAIN + 1; j++) begin
      if (j <= len) begin
        IN_VALID = (jv[j-1] != 0);
        IN_LAST  = (j == len);
        A_IN     = mkvec(jv[j-1], off, 0);
        B_IN     = mkvec(jv[j-1], off, 256);
        chk({name, " rdy_pre"}, 128'(IN_READY), 128'(1));
        if (jv[j-1] != 0) ecnt++;
      end else if (flush_valid) begin
        IN_VALID = 1'b1;
        IN_LAST  = 1'b0;
        A_IN     = mkvec(9, 0, 0);
        B_IN     = mkvec(9, 0, 0);
      end else begin
        IN_VALID = 1'b0;
        IN_LAST  = 1'b0;
        A_IN     = '0;
        B_IN     = '0;
      end
      tick();
      ea = '0;
      eb = '0;
      for (int i = 0; i < N; i++) begin
        d = j - i;
        if (d >= 1 && d <= len) begin
          ea[i*WIDTH +: WIDTH] = lanev(jv[d-1], off, i, 0);
          eb[i*WIDTH +: WIDTH] = lanev(jv[d-1], off, i, 256);
        end
      end
      chk({name, " aa"}, 128'(AA), 128'(ea));
      chk({name, " bb"}, 128'(BB), 128'(eb));
      chk({name, " busy"}, 128'(BUSY), 128'(j <= len + DRAIN - 1));
      chk({name, " done"}, 128'(DONE), 128'(j == len + DRAIN));
      chk({name, " rdy"}, 128'(IN_READY), 128'((j < len) || (j >= len + DRAIN + 1)));
      chk({name, " vec_cnt"}, 128'(VEC_CNT), 128'(ecnt));
    end
    IN_VALID = 1'b0;
    IN_LAST  = 1'b0;
    A_IN     = '0;
    B_IN     = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    RST      = 1'b1;
    IN_VALID = 1'b1;
    IN_LAST  = 1'($urandom_range(0, 1));
    A_IN     = {$urandom, $urandom, $urandom, $urandom};
    B_IN     = {$urandom, $urandom, $urandom, $urandom};
    tick();
    A_IN     = {$urandom, $urandom, $urandom, $urandom};
    IN_LAST  = 1'($urandom_range(0, 1));
    tick();
    chk("rst aa", 128'(AA), 128'(0));
    chk("rst bb", 128'(BB), 128'(0));
    chk("rst vec_cnt", 128'(VEC_CNT), 128'(0));
    chk("rst busy", 128'(BUSY), 128'(0));
    chk("rst done", 128'(DONE), 128'(0));
    chk("rst rdy", 128'(IN_READY), 128'(1));
    RST      = 1'b0;
    IN_VALID = 1'b0;
    IN_LAST  = 1'b0;
    A_IN     = '0;
    B_IN     = '0;
    tick();

    jv = '{1, 0, 0, 0, 0, 0, 0, 0};
    run_job("single", 1, 1, 1'b0);

    jv = '{1, 2, 3, 4, 0, 0, 0, 0};
    run_job("ramp", 4, 0, 1'b0);

    jv = '{1, 0, 2, 0, 0, 0, 0, 0};
    run_job("bubble", 3, 0, 1'b0);

    jv = '{3, 0, 0, 0, 0, 0, 0, 0};
    run_job("flushvld", 1, 0, 1'b1);

    // Abort a job in its third flush cycle; lane 2 still holds data at that point.
    IN_VALID = 1'b1;
    IN_LAST  = 1'b1;
    A_IN     = mkvec(5, 0, 0);
    B_IN     = mkvec(5, 0, 0);
    tick();
    IN_VALID = 1'b0;
    IN_LAST  = 1'b0;
    A_IN     = '0;
    B_IN     = '0;
    tick();
    tick();
    chk("abort pre aa", 128'(AA), 128'({32'd0, 32'd5, 32'd0, 32'd0}));
    chk("abort pre busy", 128'(BUSY), 128'(1));
    RST = 1'b1;
    tick();
    RST = 1'b0;
    chk("abort aa", 128'(AA), 128'(0));
    chk("abort bb", 128'(BB), 128'(0));
    chk("abort rdy", 128'(IN_READY), 128'(1));
    chk("abort busy", 128'(BUSY), 128'(0));
    chk("abort done", 128'(DONE), 128'(0));
    chk("abort vec_cnt", 128'(VEC_CNT), 128'(0));
    for (int k = 0; k < 8; k++) begin
      tick();
      chk("abort no_done", 128'(DONE), 128'(0));
      chk("abort idle_aa", 128'(AA), 128'(0));
      chk("abort idle_rdy", 128'(IN_READY), 128'(1));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
